// File: rtl/dss_pkg.sv
// rtl/dss_pkg.sv - shared constants, state encoding and PN step function for the DSSS spreader
package dss_pkg;

    localparam int         PN_LEN   = 127;
    localparam logic [6:0] PN_SEED  = 7'h7F;
    localparam int         PN_TAP_A = 6;
    localparam int         PN_TAP_B = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Fibonacci x^7+x^6+1: shift left, feedback into bit 0
    function automatic logic [6:0] pn_next(input logic [6:0] s);
        return {s[5:0], s[PN_TAP_A] ^ s[PN_TAP_B]};
    endfunction

endpackage

// File: rtl/pn_lfsr7.sv
// rtl/pn_lfsr7.sv - 7-bit m-sequence generator; load forces the seed, en steps one chip
module pn_lfsr7
    import dss_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    output logic pn
);

    logic [6:0] r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PN_SEED;
        end else if (load) begin
            r_state <= PN_SEED;
        end else if (en) begin
            r_state <= pn_next(r_state);
        end
    end

    assign pn = r_state[6];

endmodule

// File: rtl/dss_bpsk_spreader.sv
// rtl/dss_bpsk_spreader.sv - DSSS spreader: one data bit per 127-chip symbol, BPSK sign-mux of the NCO carrier
module dss_bpsk_spreader
    import dss_pkg::*;
#(
    parameter int DW       = 10,
    parameter int CHIP_DIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clken,
    input  logic [DW-1:0] car_i,
    input  logic          car_valid,
    input  logic          din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          chip_o,
    output logic          sym_start,
    output logic          underrun
);

    localparam int              SMP_W    = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(CHIP_DIV - 1);
    localparam logic [6:0]       IDX_LAST = 7'(PN_LEN - 1);
    localparam logic [DW-1:0]    CAR_MIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]    CAR_MAX  = {1'b0, {(DW-1){1'b1}}};

    state_t           r_state;
    state_t           w_next_state;
    logic [SMP_W-1:0] r_smp;
    logic [6:0]       r_idx;
    logic             r_bit;

    logic             w_adv;
    logic             w_chip_end;
    logic             w_boundary;
    logic             w_accept;
    logic             w_underrun;
    logic             w_pn;
    logic             w_chip;
    logic             w_run_adv;
    logic [DW-1:0]    w_neg;
    logic [DW-1:0]    w_mix;

    assign w_adv      = clken & car_valid;
    assign w_run_adv  = (r_state == RUN) & w_adv;
    assign w_chip_end = w_adv & (r_smp == SMP_LAST);
    assign w_boundary = w_chip_end & (r_idx == IDX_LAST);
    assign w_chip     = r_bit ^ w_pn;
    // The most negative carrier has no positive twin; clamp instead of wrapping
    assign w_neg      = (car_i == CAR_MIN) ? CAR_MAX : (~car_i + 1'b1);
    assign w_mix      = w_chip ? w_neg : car_i;

    pn_lfsr7 u_pn (
        .clk   (clk),
        .reset (reset),
        .en    ((r_state == RUN) & w_chip_end),
        .load  (w_accept),
        .pn    (w_pn)
    );

    always_comb begin
        w_next_state = r_state;
        din_ready    = 1'b0;
        w_accept     = 1'b0;
        w_underrun   = 1'b0;
        case (r_state)
            IDLE: begin
                din_ready = clken;
                w_accept  = din_valid & clken;
                if (w_accept) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                din_ready = w_boundary;
                w_accept  = w_boundary & din_valid;
                if (w_boundary && !din_valid) begin
                    w_underrun   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_bit   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_bit <= din;
            end
        end
    end

    // Counters wrap to zero exactly at the symbol boundary, so both the
    // seamless-restart and underrun paths leave them cleared without extra logic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_smp <= '0;
            r_idx <= '0;
        end else if (w_run_adv) begin
            if (r_smp == SMP_LAST) begin
                r_smp <= '0;
                r_idx <= (r_idx == IDX_LAST) ? 7'd0 : r_idx + 7'd1;
            end else begin
                r_smp <= r_smp + SMP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            chip_o     <= 1'b0;
            sym_start  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sym_start  <= 1'b0;
            underrun   <= w_underrun;
            if (w_run_adv) begin
                dout       <= w_mix;
                dout_valid <= 1'b1;
                chip_o     <= w_chip;
                sym_start  <= (r_smp == '0) && (r_idx == 7'd0);
            end
        end
    end

endmodule
